// File: rtl/mod_seq_pkg.sv
// Shared types and helpers for the modulation/sequence index scheduler.
package mod_seq_pkg;

   localparam int IDX_W_DEF = 16;
   localparam int DIV_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_SYNC = 2'd1,
      RUN       = 2'd2
   } sched_state_t;

   // A divider of zero would never reach its terminal count, so it behaves as one.
   function automatic logic [31:0] div_norm(input logic [31:0] div);
      return (div == 32'd0) ? 32'd1 : div;
   endfunction

endpackage

// File: rtl/idx_stepper.sv
// One paced index: tick divider, wrapping index and a one-cycle step pulse.
module idx_stepper #(
   parameter int IDX_W = 16,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic             tick,
   input  logic             realign,
   input  logic [IDX_W-1:0] cycle,
   input  logic [DIV_W-1:0] div,
   output logic [IDX_W-1:0] idx,
   output logic             step,
   output logic             cnt_zero
);

   logic [DIV_W-1:0] div_cnt;
   logic             terminal;

   // The >= comparison keeps the counter bounded even if div shrinks mid-count.
   assign terminal = (div_cnt >= (div - DIV_W'(1)));
   assign cnt_zero = (div_cnt == '0);

   // A realign discards any tick in the same cycle so the phase restarts cleanly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         idx     <= '0;
         step    <= 1'b0;
      end else begin
         step <= 1'b0;
         if (clear) begin
            div_cnt <= '0;
            idx     <= '0;
         end else if (realign) begin
            div_cnt <= '0;
         end else if (enable && tick) begin
            if (terminal) begin
               div_cnt <= '0;
               step    <= 1'b1;
               idx     <= (idx >= cycle) ? '0 : idx + IDX_W'(1);
            end else begin
               div_cnt <= div_cnt + DIV_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/mod_seq_scheduler.sv
// Paces MOD_IDX/SEQ_IDX from REF_CLK_TICK, started on a SYNC0 edge.
// Optional SYNC-in-RUN drift realignment is enabled by defining MOD_SEQ_RESYNC_EN.
module mod_seq_scheduler
   import mod_seq_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sync,
   input  logic             ref_clk_tick,
   input  logic             cfg_load,
   input  logic [IDX_W-1:0] mod_clk_cycle,
   input  logic [DIV_W-1:0] mod_clk_div,
   input  logic [IDX_W-1:0] seq_clk_cycle,
   input  logic [DIV_W-1:0] seq_clk_div,
   output logic [IDX_W-1:0] mod_idx,
   output logic [IDX_W-1:0] seq_idx,
   output logic             mod_step,
   output logic             seq_step,
   output logic             running,
   output logic             desync
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_WAIT = WAIT_SYNC;
   localparam logic [1:0] ST_RUN  = RUN;

   logic [1:0]       state;
   logic [IDX_W-1:0] mod_cycle_q;
   logic [IDX_W-1:0] seq_cycle_q;
   logic [DIV_W-1:0] mod_div_q;
   logic [DIV_W-1:0] seq_div_q;

   logic             clear;
   logic             enable;
   logic             mod_realign;
   logic             seq_realign;
   logic             mod_cnt_zero;
   logic             seq_cnt_zero;

   // CFG_LOAD re-arms from any state, so it takes priority over SYNC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else if (cfg_load) begin
         state <= ST_WAIT;
      end else if ((state == ST_WAIT) && sync) begin
         state <= ST_RUN;
      end
   end

   // Shadow config keeps the run stable while config_manager rewrites its inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mod_cycle_q <= '0;
         seq_cycle_q <= '0;
         mod_div_q   <= '0;
         seq_div_q   <= '0;
      end else if (cfg_load) begin
         mod_cycle_q <= mod_clk_cycle;
         seq_cycle_q <= seq_clk_cycle;
         mod_div_q   <= DIV_W'(div_norm(32'(mod_clk_div)));
         seq_div_q   <= DIV_W'(div_norm(32'(seq_clk_div)));
      end
   end

   assign clear   = cfg_load || ((state == ST_WAIT) && sync);
   assign enable  = (state == ST_RUN);
   assign running = (state == ST_RUN);

`ifdef MOD_SEQ_RESYNC_EN
   logic resync;

   // Only a counter that has drifted off phase zero gets pulled back.
   assign resync      = (state == ST_RUN) && sync && !cfg_load;
   assign mod_realign = resync && !mod_cnt_zero;
   assign seq_realign = resync && !seq_cnt_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         desync <= 1'b0;
      end else if (cfg_load) begin
         desync <= 1'b0;
      end else if (mod_realign || seq_realign) begin
         desync <= 1'b1;
      end
   end
`else
   logic unused_cnt_zero;

   assign mod_realign     = 1'b0;
   assign seq_realign     = 1'b0;
   assign desync          = 1'b0;
   assign unused_cnt_zero = mod_cnt_zero ^ seq_cnt_zero;
`endif

   idx_stepper #(
      .IDX_W (IDX_W),
      .DIV_W (DIV_W)
   ) u_mod_stepper (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .enable   (enable),
      .tick     (ref_clk_tick),
      .realign  (mod_realign),
      .cycle    (mod_cycle_q),
      .div      (mod_div_q),
      .idx      (mod_idx),
      .step     (mod_step),
      .cnt_zero (mod_cnt_zero)
   );

   idx_stepper #(
      .IDX_W (IDX_W),
      .DIV_W (DIV_W)
   ) u_seq_stepper (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .enable   (enable),
      .tick     (ref_clk_tick),
      .realign  (seq_realign),
      .cycle    (seq_cycle_q),
      .div      (seq_div_q),
      .idx      (seq_idx),
      .step     (seq_step),
      .cnt_zero (seq_cnt_zero)
   );

endmodule

// File: tb/tb_mod_seq_scheduler.sv
// Scoreboard bench for mod_seq_scheduler: stimulus queues expected steps, a monitor checks them.
module tb_mod_seq_scheduler;

   typedef struct {
      logic [15:0] idx;
      int          due;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        sync;
   logic        ref_clk_tick;
   logic        cfg_load;
   logic [15:0] mod_clk_cycle;
   logic [15:0] mod_clk_div;
   logic [15:0] seq_clk_cycle;
   logic [15:0] seq_clk_div;
   logic [15:0] mod_idx;
   logic [15:0] seq_idx;
   logic        mod_step;
   logic        seq_step;
   logic        running;
   logic        desync;

   exp_t mod_q[$];
   exp_t seq_q[$];
   int   cyc      = 0;
   int   compared = 0;
   int   failed   = 0;

   mod_seq_scheduler #(
      .IDX_W (16),
      .DIV_W (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .sync          (sync),
      .ref_clk_tick  (ref_clk_tick),
      .cfg_load      (cfg_load),
      .mod_clk_cycle (mod_clk_cycle),
      .mod_clk_div   (mod_clk_div),
      .seq_clk_cycle (seq_clk_cycle),
      .seq_clk_div   (seq_clk_div),
      .mod_idx       (mod_idx),
      .seq_idx       (seq_idx),
      .mod_step      (mod_step),
      .seq_step      (seq_step),
      .running       (running),
      .desync        (desync)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // One cycle of stimulus, then idle; expected steps are due one edge after the pulse.
   task automatic applyStimulus(input logic s, input logic t, input logic l,
                                input bit push_mod, input logic [15:0] mod_exp,
                                input bit push_seq, input logic [15:0] seq_exp);
      exp_t e;
      @(negedge clk);
      if (push_mod) begin
         e.idx = mod_exp;
         e.due = cyc + 1;
         mod_q.push_back(e);
      end
      if (push_seq) begin
         e.idx = seq_exp;
         e.due = cyc + 1;
         seq_q.push_back(e);
      end
      sync         = s;
      ref_clk_tick = t;
      cfg_load     = l;
      @(negedge clk);
      sync         = 1'b0;
      ref_clk_tick = 1'b0;
      cfg_load     = 1'b0;
   endtask

   // Every STEP pulse must match the oldest queued expectation, in value and timing.
   always @(negedge clk) begin
      exp_t e;
      if (mod_step === 1'b1) begin
         if (mod_q.size() == 0) begin
            compared++;
            failed++;
            $display("[TB] FAIL unexpected_mod_step: got step idx %0d, expected no step (cycle %0d)", mod_idx, cyc);
         end else begin
            e = mod_q.pop_front();
            checkOutput("mod_idx_at_step", 32'(mod_idx), 32'(e.idx));
            checkOutput("mod_step_cycle", cyc, e.due);
         end
      end
      if (seq_step === 1'b1) begin
         if (seq_q.size() == 0) begin
            compared++;
            failed++;
            $display("[TB] FAIL unexpected_seq_step: got step idx %0d, expected no step (cycle %0d)", seq_idx, cyc);
         end else begin
            e = seq_q.pop_front();
            checkOutput("seq_idx_at_step", 32'(seq_idx), 32'(e.idx));
            checkOutput("seq_step_cycle", cyc, e.due);
         end
      end
   end

   initial begin
      rst           = 1'b1;
      sync          = 1'b0;
      ref_clk_tick  = 1'b0;
      cfg_load      = 1'b0;
      mod_clk_cycle = 16'd0;
      mod_clk_div   = 16'd0;
      seq_clk_cycle = 16'd0;
      seq_clk_div   = 16'd0;

      @(negedge clk);
      checkOutput("reset_mod_idx", 32'(mod_idx), 0);
      checkOutput("reset_seq_idx", 32'(seq_idx), 0);
      checkOutput("reset_mod_step", 32'(mod_step), 0);
      checkOutput("reset_seq_step", 32'(seq_step), 0);
      checkOutput("reset_running", 32'(running), 0);
      checkOutput("reset_desync", 32'(desync), 0);
      rst = 1'b0;

      // Armed but never synced: ticks must not move anything.
      mod_clk_cycle = 16'd3;
      mod_clk_div   = 16'd2;
      seq_clk_cycle = 16'd0;
      seq_clk_div   = 16'd0;
      applyStimulus(1'b0, 1'b0, 1'b1, 0, 16'd0, 0, 16'd0);
      checkOutput("armed_running", 32'(running), 0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0, 16'd0, 0, 16'd0);
      checkOutput("nosync_mod_idx", 32'(mod_idx), 0);
      checkOutput("nosync_running", 32'(running), 0);

      applyStimulus(1'b1, 1'b0, 1'b0, 0, 16'd0, 0, 16'd0);
      checkOutput("sync_running", 32'(running), 1);
      checkOutput("sync_mod_idx", 32'(mod_idx), 0);

      // With div=2 and cycle=3 the mod index steps on even ticks; the seq index (cycle=0, div=0) steps every tick at 0.
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, (i % 2) == 0, 16'((i / 2) % 4), 1, 16'd0);
      end
      checkOutput("wrap_mod_idx", 32'(mod_idx), 0);
      checkOutput("wrap_seq_idx", 32'(seq_idx), 0);

      applyStimulus(1'b0, 1'b1, 1'b0, 0, 16'd0, 1, 16'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1, 16'd1, 1, 16'd0);
      checkOutput("pre_reload_mod_idx", 32'(mod_idx), 1);

      // CFG_LOAD beats a coincident SYNC: back to waiting with indices cleared.
      applyStimulus(1'b1, 1'b0, 1'b1, 0, 16'd0, 0, 16'd0);
      checkOutput("reload_running", 32'(running), 0);
      checkOutput("reload_mod_idx", 32'(mod_idx), 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 16'd0, 0, 16'd0);
      checkOutput("wait_tick_mod_idx", 32'(mod_idx), 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 16'd0, 0, 16'd0);
      checkOutput("resync_running", 32'(running), 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 16'd0, 1, 16'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1, 16'd1, 1, 16'd0);
      checkOutput("restart_mod_idx", 32'(mod_idx), 1);

      // SYNC while running, MOD div=3, SEQ div=1 so the seq counter never drifts.
      mod_clk_cycle = 16'd3;
      mod_clk_div   = 16'd3;
      seq_clk_cycle = 16'd0;
      seq_clk_div   = 16'd1;
      applyStimulus(1'b0, 1'b0, 1'b1, 0, 16'd0, 0, 16'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 16'd0, 0, 16'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 16'd0, 0, 16'd0);
      checkOutput("sync_at_zero_desync", 32'(desync), 0);
`ifdef MOD_SEQ_RESYNC_EN
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 16'd0, 1, 16'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 16'd0, 0, 16'd0);
      checkOutput("drift_desync", 32'(desync), 1);
      checkOutput("drift_mod_idx", 32'(mod_idx), 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 16'd0, 1, 16'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 16'd0, 1, 16'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1, 16'd1, 1, 16'd0);
      checkOutput("sticky_desync", 32'(desync), 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 16'd0, 1, 16'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 0, 16'd0, 1, 16'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 16'd0, 1, 16'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 16'd0, 1, 16'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1, 16'd2, 1, 16'd0);
      checkOutput("realigned_mod_idx", 32'(mod_idx), 2);
`else
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 16'd0, 1, 16'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 16'd0, 0, 16'd0);
      checkOutput("ignored_sync_desync", 32'(desync), 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 16'd0, 1, 16'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1, 16'd1, 1, 16'd0);
      checkOutput("ignored_sync_mod_idx", 32'(mod_idx), 1);
      checkOutput("ignored_sync_running", 32'(running), 1);
`endif

      // Asynchronous reset between edges clears outputs immediately.
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_mod_idx", 32'(mod_idx), 0);
      checkOutput("async_rst_seq_idx", 32'(seq_idx), 0);
      checkOutput("async_rst_running", 32'(running), 0);
      checkOutput("async_rst_desync", 32'(desync), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0, 16'd0, 0, 16'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 16'd0, 0, 16'd0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0, 16'd0, 0, 16'd0);
      checkOutput("post_rst_mod_idx", 32'(mod_idx), 0);
      checkOutput("post_rst_running", 32'(running), 0);

      repeat (2) @(negedge clk);
      checkOutput("mod_q_drained", 32'(mod_q.size()), 0);
      checkOutput("seq_q_drained", 32'(seq_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
